// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared defaults and sizing helpers for the instruction prefetch queue.
package fetch_prefetch_queue_pkg;

  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_PC_STEP  = 32'd1;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// In-order queue of {pc, inst} entries with push, pop, flush and occupancy count.
module fetch_prefetch_queue_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full || do_pop);
  // Empty queue presents zeros so the head is clean after reset.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  push_when_full_a : assert property (@(posedge clk) disable iff (!rst)
    !(push_i && full && !do_pop));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited imem requests, in-order response queue, redirect flush.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned      DEPTH    = DEF_DEPTH,
  parameter int unsigned      ADDR_W   = DEF_ADDR_W,
  parameter int unsigned      DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEF_PC_STEP),
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  localparam int unsigned     CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectTarget,
  output logic              imemReqValid,
  output logic [ADDR_W-1:0] imemReqAddr,
  input  logic              imemReqReady,
  input  logic              imemRspValid,
  input  logic [DATA_W-1:0] imemRspData,
  output logic              outValid,
  output logic [ADDR_W-1:0] outPc,
  output logic [DATA_W-1:0] outInst,
  input  logic              outReady,
  output logic [CNT_W-1:0]  occupancy
);

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]        rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]         in_flight_q, in_flight_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]           committed;
  logic                     accept, push;
  logic [ADDR_W+DATA_W-1:0] head;

  // Every slot is either buffered or owed by imem, so the queue can never overflow.
  assign committed    = {1'b0, occupancy} + {1'b0, in_flight_q};
  assign imemReqValid = rst && !redirectValid && (committed < (CNT_W+1)'(DEPTH));
  assign imemReqAddr  = fetch_pc_q;
  assign accept       = imemReqValid && imemReqReady;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    drop_cnt_d  = drop_cnt_q;
    push        = 1'b0;
    in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(imemRspValid);
    if (redirectValid) begin
      // Everything still owed by imem belongs to the old path; a response this cycle is already gone.
      fetch_pc_d = redirectTarget;
      rsp_pc_d   = redirectTarget;
      drop_cnt_d = in_flight_q - CNT_W'(imemRspValid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (imemRspValid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fetch_prefetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirectValid),
    .push_i  (push),
    .data_i  ({rsp_pc_q, imemRspData}),
    .pop_i   (outReady),
    .data_o  (head),
    .valid_o (outValid),
    .count_o (occupancy)
  );

  assign outPc   = head[ADDR_W+DATA_W-1 -: ADDR_W];
  assign outInst = head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an imem latency model and an expected-output scoreboard.
module tb_fetch_prefetch_queue;

  logic        clk, rst;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        imemReqValid, imemReqReady, imemRspValid;
  logic [31:0] imemReqAddr, imemRspData;
  logic        outValid, outReady;
  logic [31:0] outPc, outInst;
  logic [2:0]  occupancy;

  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .imemRspValid(imemRspValid), .imemRspData(imemRspData),
    .outValid(outValid), .outPc(outPc), .outInst(outInst), .outReady(outReady),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] act;
    logic [31:0] expa;
    int          due;
    int          ep;
  } req_t;

  req_t        pend[$];
  req_t        cur;
  logic [63:0] sb[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc, held_pc, held_inst, exp_head;
  int          checks, errors, cyc, lat, epoch, dropped, pops;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[23:0], 8'h3C};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, then drive the imem response for the next cycle.
  task automatic tick();
    @(negedge clk);
    if (outValid && outReady) begin
      pops++;
      pop_log.push_back(outPc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL pop_unexpected observed_pc=%0h expected=no_output", outPc);
      end else begin
        chk("pop", {outPc, outInst}, sb.pop_front());
      end
    end
    if (imemRspValid) begin
      if (cur.ep == epoch && !redirectValid) sb.push_back({cur.expa, mem_word(cur.expa)});
      else dropped++;
    end
    if (redirectValid) begin
      chk("redirect_no_req", {63'd0, imemReqValid}, 64'd0);
      sb.delete();
      epoch++;
      exp_pc = redirectTarget;
    end else if (imemReqValid && imemReqReady) begin
      chk("req_addr", {32'd0, imemReqAddr}, {32'd0, exp_pc});
      pend.push_back('{act: imemReqAddr, expa: exp_pc, due: cyc + lat, ep: epoch});
      exp_pc = exp_pc + 32'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      cur          = pend.pop_front();
      imemRspValid = 1'b1;
      imemRspData  = mem_word(cur.act);
    end else begin
      imemRspValid = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    pend.delete();
    sb.delete();
    epoch++;
    exp_pc       = 32'd0;
    imemRspValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1; epoch = 0; dropped = 0; pops = 0;
    exp_pc = 32'd0;
    cur = '{act: 32'd0, expa: 32'd0, due: 0, ep: -1};
    rst = 1'b1; redirectValid = 1'b0; redirectTarget = 32'd0;
    imemReqReady = 1'b1; imemRspValid = 1'b0; imemRspData = 32'd0; outReady = 1'b1;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_outValid", {63'd0, outValid}, 64'd0);
    chk("rst_outPc", {32'd0, outPc}, 64'd0);
    chk("rst_outInst", {32'd0, outInst}, 64'd0);
    chk("rst_occupancy", {61'd0, occupancy}, 64'd0);
    chk("rst_reqValid", {63'd0, imemReqValid}, 64'd0);
    ticks(2);
    #2 rst = 1'b1;

    // 1: streaming at one instruction per cycle
    pop_log.delete();
    ticks(4);
    pops = 0;
    ticks(10);
    chk("t1_throughput", 64'(pops), 64'd10);
    chk("t1_first_pc", {32'd0, pop_log[0]}, 64'd0);
    chk("t1_second_pc", {32'd0, pop_log[1]}, 64'd1);

    // 2: consumer stall fills the queue and holds the head
    outReady = 1'b0;
    tick();
    held_pc = outPc;
    held_inst = outInst;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_stable_pc", {32'd0, outPc}, {32'd0, held_pc});
      chk("t2_stable_inst", {32'd0, outInst}, {32'd0, held_inst});
    end
    chk("t2_occupancy", {61'd0, occupancy}, 64'd4);
    chk("t2_reqValid", {63'd0, imemReqValid}, 64'd0);
    chk("t2_outValid", {63'd0, outValid}, 64'd1);
    pop_log.delete();
    outReady = 1'b1;
    ticks(12);
    chk("t2_resume_pc", {32'd0, pop_log[0]}, {32'd0, held_pc});
    chk("t2_resume_next", {32'd0, pop_log[1]}, {32'd0, held_pc + 32'd1});

    // 3: latency 3, redirect with three requests outstanding
    imemReqReady = 1'b0;
    ticks(6);
    lat = 3;
    dropped = 0;
    imemReqReady = 1'b1;
    ticks(3);
    redirectValid = 1'b1;
    redirectTarget = 32'h40;
    tick();
    redirectValid = 1'b0;
    pop_log.delete();
    ticks(12);
    chk("t3_dropped", 64'(dropped), 64'd3);
    chk("t3_first_pc", {32'd0, pop_log[0]}, 64'h40);
    chk("t3_second_pc", {32'd0, pop_log[1]}, 64'h41);

    // 4: redirect coinciding with a response and a pop
    lat = 1;
    ticks(8);
    chk("t4_head_valid", {63'd0, outValid}, 64'd1);
    exp_head = sb[0][63:32];
    pop_log.delete();
    redirectValid = 1'b1;
    redirectTarget = 32'h40;
    tick();
    redirectValid = 1'b0;
    ticks(6);
    chk("t4_popped_once", {32'd0, pop_log[0]}, {32'd0, exp_head});
    chk("t4_after_redirect", {32'd0, pop_log[1]}, 64'h40);

    // 5: asynchronous reset between edges
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("t5_outValid", {63'd0, outValid}, 64'd0);
    chk("t5_occupancy", {61'd0, occupancy}, 64'd0);
    chk("t5_reqValid", {63'd0, imemReqValid}, 64'd0);
    ticks(2);
    #2 rst = 1'b1;
    #1;
    chk("t5_first_addr", {32'd0, imemReqAddr}, 64'd0);
    chk("t5_first_valid", {63'd0, imemReqValid}, 64'd1);
    pop_log.delete();
    ticks(6);
    chk("t5_first_pc", {32'd0, pop_log[0]}, 64'd0);

    // 6: PC wraparound
    redirectValid = 1'b1;
    redirectTarget = 32'hFFFF_FFFF;
    tick();
    redirectValid = 1'b0;
    pop_log.delete();
    ticks(6);
    chk("t6_pc_max", {32'd0, pop_log[0]}, 64'hFFFF_FFFF);
    chk("t6_pc_wrap", {32'd0, pop_log[1]}, 64'd0);
    chk("t6_pc_next", {32'd0, pop_log[2]}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
